instr_encoder_loader: RTL and testbench

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

---
 rtl/isa_pkg.sv | 53 +++++
 rtl/enc_fifo.sv | 80 ++++++++
 rtl/instr_encoder_loader.sv | 238 +++++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// ----------------------------------------------------------------------------
// isa_pkg
// Shared instruction-set definitions: field widths, field bit positions inside
// the 32-bit instruction word, the illegal opType code, the loader state enum
// and the field-to-word encoder. The control unit slices words using the same
// positions, so the encoder here is the exact inverse of that slicing.
//
// Word layout (bit 31 .. bit 0):
//   opType[31:30] | opCode[29:26] | Rd[25:22] | Rn[21:18] | imm[17:0]
// ----------------------------------------------------------------------------
package isa_pkg;

   localparam int unsigned WORD_W     = 32;

   localparam int unsigned OPTYPE_W   = 2;
   localparam int unsigned OPCODE_W   = 4;
   localparam int unsigned REG_W      = 4;
   localparam int unsigned IMM_W      = 18;

   localparam int unsigned OPTYPE_LSB = 30;
   localparam int unsigned OPCODE_LSB = 26;
   localparam int unsigned RD_LSB     = 22;
   localparam int unsigned RN_LSB     = 18;
   localparam int unsigned IMM_LSB    = 0;

   // opType 2'b11 has no decoding in the control unit; such beats are dropped.
   localparam logic [OPTYPE_W-1:0] OPTYPE_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } enc_state_e;

   function automatic logic [WORD_W-1:0] encode_word(
      input logic [OPTYPE_W-1:0] op_type,
      input logic [OPCODE_W-1:0] op_code,
      input logic [REG_W-1:0]    rd,
      input logic [REG_W-1:0]    rn,
      input logic [IMM_W-1:0]    imm
   );
      logic [WORD_W-1:0] w;
      w = '0;
      w[OPTYPE_LSB +: OPTYPE_W] = op_type;
      w[OPCODE_LSB +: OPCODE_W] = op_code;
      w[RD_LSB     +: REG_W]    = rd;
      w[RN_LSB     +: REG_W]    = rn;
      w[IMM_LSB    +: IMM_W]    = imm;
      return w;
   endfunction

endpackage

// File: rtl/enc_fifo.sv
// ----------------------------------------------------------------------------
// enc_fifo
// Synchronous FIFO buffering encoded instruction words between the field
// handshake and the instruction-memory write port. Head entry is shown on
// dout whenever the FIFO is non-empty. full/empty come straight from the
// registered occupancy counter. A push while full or a pop while empty is
// ignored. Push and pop in the same cycle leave the occupancy unchanged.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset (empties the FIFO)
//   push   in   write din at the tail
//   din    in   WIDTH-bit data to write
//   pop    in   drop the head entry
//   dout   out  head entry
//   full   out  DEPTH entries held
//   empty  out  no entries held
// ----------------------------------------------------------------------------
module enc_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic w_do_push;
   logic w_do_pop;

   assign full      = (r_count == CNT_FULL);
   assign empty     = (r_count == '0);
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign dout      = r_mem[r_rd_ptr];

   // Storage carries no reset; stale entries are never visible while empty.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Depth is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader
// Accepts instruction fields over a valid/ready handshake, encodes each beat
// into a 32-bit word, buffers it in enc_fifo and writes the words to
// consecutive instruction-memory addresses starting at base_addr. Beats with
// the illegal opType are dropped and counted. The load ends once the in_last
// beat has been accepted and every buffered word has been acknowledged.
//
// Optional feature (compile-time macro ENC_CHECKSUM_EN):
//   adds output checksum = XOR of all acknowledged words of the current load.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset, aborts any load
//   start      in   one-cycle pulse, begins a load (ignored unless idle)
//   base_addr  in   first write address, sampled on start
//   in_valid   in   field beat valid
//   in_ready   out  loader can take a beat this cycle
//   opType, opCode, Rd, Rn, imm   in   instruction fields
//   in_last    in   current beat is the final instruction
//   mem_we     out  write request, held until mem_ack
//   mem_addr   out  write address
//   mem_wdata  out  write data
//   mem_ack    in   write accepted
//   busy       out  load in progress
//   done       out  one-cycle pulse at the end of a load
//   wrap       out  write address rolled over to 0 during this load
//   err        out  an illegal beat was seen since reset (sticky)
//   err_cnt    out  illegal beats since reset, saturating at 255
//   word_cnt   out  acknowledged writes in this load
//   checksum   out  (ENC_CHECKSUM_EN only) XOR of acknowledged words
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// LOAD  | accepting beats, writing buffered words
// FLUSH | last beat taken, draining the buffer to memory
// DONE  | load complete, done pulse, back to IDLE next cycle
// ----------------------------------------------------------------------------
module instr_encoder_loader
   import isa_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          opType,
   input  logic [3:0]          opCode,
   input  logic [3:0]          Rd,
   input  logic [3:0]          Rn,
   input  logic [17:0]         imm,
   input  logic                in_last,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [31:0]         mem_wdata,
   input  logic                mem_ack,
   output logic                busy,
   output logic                done,
   output logic                wrap,
   output logic                err,
   output logic [7:0]          err_cnt,
   output logic [ADDR_W:0]     word_cnt
`ifdef ENC_CHECKSUM_EN
   ,
   output logic [31:0]         checksum
`endif
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [7:0]        ERR_MAX  = 8'hFF;

   enc_state_e r_state;
   enc_state_e w_next_state;

   logic [ADDR_W-1:0] r_addr;
   logic              r_wrap;
   logic              r_err;
   logic [7:0]        r_err_cnt;
   logic [ADDR_W:0]   r_word_cnt;

   logic        w_fifo_full;
   logic        w_fifo_empty;
   logic [31:0] w_fifo_dout;
   logic [31:0] w_enc_word;
   logic        w_xfer;
   logic        w_illegal;
   logic        w_push;
   logic        w_pop;
   logic        w_start_load;

   assign w_enc_word   = encode_word(opType, opCode, Rd, Rn, imm);
   assign w_xfer       = in_valid && in_ready;
   assign w_illegal    = (opType == OPTYPE_ILLEGAL);
   assign w_push       = w_xfer && !w_illegal;
   assign w_pop        = mem_we && mem_ack;
   assign w_start_load = (r_state == ST_IDLE) && start;

   enc_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .din   (w_enc_word),
      .pop   (w_pop),
      .dout  (w_fifo_dout),
      .full  (w_fifo_full),
      .empty (w_fifo_empty)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (w_xfer && in_last) begin
               w_next_state = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // Empty buffer means no write request is outstanding either.
            if (w_fifo_empty) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      in_ready = 1'b0;
      mem_we   = 1'b0;
      case (r_state)
         ST_LOAD: begin
            busy     = 1'b1;
            in_ready = !w_fifo_full;
            mem_we   = !w_fifo_empty;
         end
         ST_FLUSH: begin
            busy   = 1'b1;
            mem_we = !w_fifo_empty;
         end
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Head entry is held in the FIFO until popped, so data is stable under a
   // stalled write; it reads as zero when no write is requested.
   assign mem_wdata = mem_we ? w_fifo_dout : 32'h0;
   assign mem_addr  = r_addr;
   assign wrap      = r_wrap;
   assign err       = r_err;
   assign err_cnt   = r_err_cnt;
   assign word_cnt  = r_word_cnt;

   // ---------------- write address, counters, status ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_addr     <= '0;
         r_wrap     <= 1'b0;
         r_word_cnt <= '0;
         r_err      <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         if (w_start_load) begin
            r_addr     <= base_addr;
            r_wrap     <= 1'b0;
            r_word_cnt <= '0;
         end else if (w_pop) begin
            r_addr     <= r_addr + ADDR_ONE;
            r_word_cnt <= r_word_cnt + CNT_ONE;
            if (r_addr == ADDR_MAX) begin
               r_wrap <= 1'b1;
            end
         end
         // Illegal beats still complete the handshake; only the word is lost.
         if (w_xfer && w_illegal) begin
            r_err <= 1'b1;
            if (r_err_cnt != ERR_MAX) begin
               r_err_cnt <= r_err_cnt + 8'd1;
            end
         end
      end
   end

`ifdef ENC_CHECKSUM_EN
   logic [31:0] r_checksum;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_checksum <= '0;
      end else if (w_start_load) begin
         r_checksum <= '0;
      end else if (w_pop) begin
         r_checksum <= r_checksum ^ w_fifo_dout;
      end
   end

   assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        opType;
   logic [3:0]        opCode;
   logic [3:0]        Rd;
   logic [3:0]        Rn;
   logic [17:0]       imm;
   logic              in_last;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic              busy;
   logic              done;
   logic              wrap;
   logic              err;
   logic [7:0]        err_cnt;
   logic [ADDR_W:0]   word_cnt;
`ifdef ENC_CHECKSUM_EN
   logic [31:0]       checksum;
`endif

   instr_encoder_loader #(
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opType    (opType),
      .opCode    (opCode),
      .Rd        (Rd),
      .Rn        (Rn),
      .imm       (imm),
      .in_last   (in_last),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap),
      .err       (err),
      .err_cnt   (err_cnt),
      .word_cnt  (word_cnt)
`ifdef ENC_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model state ----------------
   logic [1:0]  b_op   [16];
   logic [3:0]  b_code [16];
   logic [3:0]  b_rd   [16];
   logic [3:0]  b_rn   [16];
   logic [17:0] b_imm  [16];

   logic [39:0] exp_q [$];     // {address, word} of each expected write, in order
   logic [7:0]  exp_base;
   int          exp_n_legal;
   logic [31:0] exp_csum;
   bit          model_err;
   int          model_err_cnt;
   int          acc_cnt;
   int          done_cnt;
   int          gap_pct;
   bit          stray_start;
   int          ack_mode;      // 0: always ack, 1: random ack, 2: never ack
   logic [31:0] last_wdata;

   // Word value from the field rules, as weighted sums of the field values.
   function automatic logic [31:0] ref_word(input logic [1:0] op, input logic [3:0] code,
                                            input logic [3:0] rd, input logic [3:0] rn,
                                            input logic [17:0] im);
      longint v;
      v = longint'(op) * 64'h4000_0000 + longint'(code) * 64'h0400_0000
        + longint'(rd) * 64'h0040_0000 + longint'(rn) * 64'h0004_0000 + longint'(im);
      return v[31:0];
   endfunction

   task automatic fill_beats(input int n, input int ill_pct);
      for (int i = 0; i < n; i++) begin
         b_op[i]   = ($urandom_range(99) < ill_pct) ? 2'b11 : 2'($urandom_range(2));
         b_code[i] = 4'($urandom);
         b_rd[i]   = 4'($urandom);
         b_rn[i]   = 4'($urandom);
         b_imm[i]  = 18'($urandom);
      end
   endtask

   // ---------------- memory acknowledge driver ----------------
   always @(posedge clk) begin
      #1;
      case (ack_mode)
         0:       mem_ack = 1'b1;
         1:       mem_ack = 1'($urandom_range(1));
         default: mem_ack = 1'b0;
      endcase
   end

   // ---------------- write monitor ----------------
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_addr;
   logic [31:0] prev_data;
   logic [39:0] mon_e;

   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            chk("hold", {mem_we, mem_addr, mem_wdata}, {1'b1, prev_addr, prev_data});
         end
         if (mem_we && mem_ack) begin
            if (exp_q.size() == 0) begin
               chk("extra_write", {mem_addr, mem_wdata}, 0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("write", {mem_addr, mem_wdata}, mon_e);
            end
            last_wdata = mem_wdata;
         end
         if (done) done_cnt++;
         prev_stall = mem_we && !mem_ack;
         prev_addr  = mem_addr;
         prev_data  = mem_wdata;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // ---------------- field driver ----------------
   task automatic send_prog(input logic [7:0] base, input int n);
      int          guard;
      bit          accepted;
      logic [31:0] w;
      @(posedge clk); #1;
      start       = 1'b1;
      base_addr   = base;
      exp_base    = base;
      exp_n_legal = 0;
      exp_csum    = '0;
      done_cnt    = 0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         accepted = 1'b0;
         guard    = 0;
         while (!accepted) begin
            in_valid  = ($urandom_range(99) >= gap_pct);
            opType    = b_op[i];
            opCode    = b_code[i];
            Rd        = b_rd[i];
            Rn        = b_rn[i];
            imm       = b_imm[i];
            in_last   = (i == n - 1);
            start     = stray_start && ($urandom_range(7) == 0);
            base_addr = 8'($urandom);
            if (in_valid && in_ready) begin
               accepted = 1'b1;
               acc_cnt++;
               if (b_op[i] == 2'b11) begin
                  model_err = 1'b1;
                  if (model_err_cnt < 255) model_err_cnt++;
               end else begin
                  w = ref_word(b_op[i], b_code[i], b_rd[i], b_rn[i], b_imm[i]);
                  exp_q.push_back({exp_base + 8'(exp_n_legal), w});
                  exp_csum = exp_csum ^ w;
                  exp_n_legal++;
               end
            end
            @(posedge clk); #1;
            guard++;
            if (!accepted && guard > 300) begin
               chk("beat_timeout", 0, 1);
               accepted = 1'b1;
               i = n;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b0;
   endtask

   task automatic end_run(input string tag);
      int  cyc;
      bit  exp_wrap;
      cyc = 0;
      while (done_cnt == 0 && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_done_seen"}, done_cnt > 0, 1);
      repeat (3) @(posedge clk);
      #1;
      exp_wrap = (exp_n_legal > 0) && (int'(exp_base) + exp_n_legal >= 256);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_done_low"}, done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_word_cnt"}, word_cnt, exp_n_legal);
      chk({tag, "_wrap"}, wrap, exp_wrap);
      chk({tag, "_err"}, err, model_err);
      chk({tag, "_err_cnt"}, err_cnt, model_err_cnt);
      chk({tag, "_pending"}, exp_q.size(), 0);
`ifdef ENC_CHECKSUM_EN
      chk({tag, "_checksum"}, checksum, exp_csum);
`endif
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_wrap"}, wrap, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_err_cnt"}, err_cnt, 0);
      chk({tag, "_word_cnt"}, word_cnt, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst_n       = 1'b0;
      start       = 1'b0;
      base_addr   = '0;
      in_valid    = 1'b0;
      opType      = '0;
      opCode      = '0;
      Rd          = '0;
      Rn          = '0;
      imm         = '0;
      in_last     = 1'b0;
      mem_ack     = 1'b0;
      ack_mode    = 0;
      gap_pct     = 0;
      stray_start = 1'b0;
      model_err     = 1'b0;
      model_err_cnt = 0;
      acc_cnt     = 0;
      done_cnt    = 0;
      exp_n_legal = 0;
      exp_base    = '0;
      exp_csum    = '0;
      last_wdata  = '0;

      repeat (3) @(posedge clk);
      #1;
      check_zero("por");
      rst_n = 1'b1;

      // base 0x10, three legal beats, ack always high
      ack_mode = 0;
      fill_beats(3, 0);
      send_prog(8'h10, 3);
      end_run("base10");

      // fixed field encoding
      b_op[0] = 2'b01; b_code[0] = 4'h2; b_rd[0] = 4'h3; b_rn[0] = 4'h4; b_imm[0] = 18'h00005;
      send_prog(8'h20, 1);
      end_run("enc");
      chk("enc_word", last_wdata, 32'h48D0_0005);

      // memory stalled: buffer fills, handshake backs off, nothing lost
      ack_mode = 2;
      acc_cnt  = 0;
      fill_beats(6, 0);
      fork
         send_prog(8'h40, 6);
      join_none
      cyc = 0;
      while (acc_cnt < DEPTH && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      repeat (10) @(posedge clk);
      #1;
      chk("stall_accepted", acc_cnt, DEPTH);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_mem_we", mem_we, 1);
      chk("stall_addr", mem_addr, 8'h40);
      chk("stall_data", mem_wdata, exp_q[0][31:0]);
      ack_mode = 0;
      end_run("stall");

      // address rollover
      fill_beats(3, 0);
      send_prog(8'hFE, 3);
      end_run("wrap");

      // illegal opType in the middle of the stream
      fill_beats(3, 0);
      b_op[1] = 2'b11;
      send_prog(8'h30, 3);
      end_run("illegal");
      chk("illegal_err_cnt_abs", err_cnt, 1);

      // only beat is illegal and last: load completes with no writes
      fill_beats(1, 100);
      send_prog(8'h50, 1);
      end_run("ill_last");

      // reset while draining the buffer
      ack_mode = 2;
      fill_beats(2, 0);
      send_prog(8'h80, 2);
      chk("flush_busy", busy, 1);
      chk("flush_in_ready", in_ready, 0);
      chk("flush_mem_we", mem_we, 1);
      rst_n    = 1'b0;
      ack_mode = 0;
      @(posedge clk); #1;
      check_zero("rst_flush");
      rst_n = 1'b1;
      exp_q.delete();
      model_err     = 1'b0;
      model_err_cnt = 0;
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_idle", {busy, mem_we, word_cnt}, 0);

      // randomized loads
      stray_start = 1'b1;
      for (int r = 0; r < 25; r++) begin
         int n;
         ack_mode = $urandom_range(1);
         gap_pct  = $urandom_range(40);
         n        = $urandom_range(10, 1);
         fill_beats(n, 20);
         send_prog(8'($urandom), n);
         end_run("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
